// File: rtl/alu_share_ctrl.sv
// Round-robin front end that time-shares one registered ALU among four requesters,
// issuing one enable pulse per accepted operation and returning the result by handshake.
module alu_share_ctrl #(
   parameter logic [2:0] ARITH_SEL = 3'b000,
   parameter int         N_REQ     = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [32*N_REQ-1:0]   req_in1,
   input  logic [32*N_REQ-1:0]   req_in2,
   input  logic [3*N_REQ-1:0]    req_sel,
   input  logic [3*N_REQ-1:0]    req_op,
   output logic [N_REQ-1:0]      resp_valid,
   output logic [31:0]           resp_data,
   output logic                  resp_err,
   input  logic [N_REQ-1:0]      resp_ack,
   output logic                  alu_enable,
   output logic [31:0]           alu_in1,
   output logic [31:0]           alu_in2,
   output logic [2:0]            alu_opselect,
   output logic [2:0]            alu_operation,
   input  logic [31:0]           alu_out,
   output logic [15:0]           op_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t     r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_idx;

   logic [31:0] w_in1 [N_REQ];
   logic [31:0] w_in2 [N_REQ];
   logic [2:0]  w_sel [N_REQ];
   logic [2:0]  w_op  [N_REQ];
   logic [1:0]  w_win;
   logic        w_any;
   logic [N_REQ-1:0] w_win_onehot;
   logic [N_REQ-1:0] w_idx_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_in1[gi] = req_in1[32*gi +: 32];
         assign w_in2[gi] = req_in2[32*gi +: 32];
         assign w_sel[gi] = req_sel[3*gi +: 3];
         assign w_op[gi]  = req_op[3*gi +: 3];
      end
   endgenerate

   // Scan from the farthest slot back to ptr+1 so the nearest valid requester wins last.
   always_comb begin
      w_win = r_ptr;
      w_any = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req_valid[r_ptr + 2'(k)]) begin
            w_win = r_ptr + 2'(k);
            w_any = 1'b1;
         end
      end
   end

   assign w_win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
   assign w_idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_idx;
   assign req_ready    = (r_state == S_IDLE && w_any && !reset) ? w_win_onehot : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_ptr         <= 2'd3;
         r_idx         <= 2'd0;
         resp_valid    <= '0;
         resp_data     <= '0;
         resp_err      <= 1'b0;
         alu_enable    <= 1'b0;
         alu_in1       <= '0;
         alu_in2       <= '0;
         alu_opselect  <= ARITH_SEL;
         alu_operation <= '0;
         op_count      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_ptr <= w_win;
                  r_idx <= w_win;
                  if (w_sel[w_win] == ARITH_SEL) begin
                     alu_enable    <= 1'b1;
                     alu_opselect  <= ARITH_SEL;
                     alu_in1       <= w_in1[w_win];
                     alu_in2       <= w_in2[w_win];
                     alu_operation <= w_op[w_win];
                     r_state       <= S_ISSUE;
                  end else begin
                     // Rejected requests never touch the ALU.
                     resp_valid <= w_win_onehot;
                     resp_err   <= 1'b1;
                     resp_data  <= '0;
                     r_state    <= S_RESP;
                  end
               end
            end
            S_ISSUE: begin
               alu_enable <= 1'b0;
               r_state    <= S_CAPTURE;
            end
            S_CAPTURE: begin
               resp_data  <= alu_out;
               resp_err   <= 1'b0;
               op_count   <= op_count + 16'd1;
               resp_valid <= w_idx_onehot;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (resp_ack[r_idx]) begin
                  resp_valid <= '0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: behavioural ALU plus a transaction-level
// round-robin/latency model, directed cases followed by randomized traffic.
module tb_alu_share_ctrl;

   localparam logic [2:0] ARITH = 3'b000;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_HADD = 3'd2;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [3:0]   req_ready;
   logic [127:0] req_in1 = '0, req_in2 = '0;
   logic [11:0]  req_sel = '0, req_op = '0;
   logic [3:0]   resp_valid;
   logic [31:0]  resp_data;
   logic         resp_err;
   logic [3:0]   resp_ack = '0;
   logic         alu_enable;
   logic [31:0]  alu_in1, alu_in2;
   logic [2:0]   alu_opselect, alu_operation;
   logic [31:0]  alu_out;
   logic [15:0]  op_count;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          m_ptr = 3;
   logic [15:0] m_count = '0;

   alu_share_ctrl #(.ARITH_SEL(ARITH), .N_REQ(4)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in1(req_in1), .req_in2(req_in2), .req_sel(req_sel), .req_op(req_op),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .resp_ack(resp_ack),
      .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_opselect(alu_opselect), .alu_operation(alu_operation),
      .alu_out(alu_out), .op_count(op_count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return {16'h0000, a[15:0] + b[15:0]};
         3'd3:    return a & b;
         3'd4:    return a | b;
         3'd5:    return a ^ b;
         3'd6:    return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   // Behavioural stand-in for the registered ALU: updates only when enabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         alu_out <= '0;
      else if (alu_enable)
         alu_out <= alu_f(alu_operation, alu_in1, alu_in2);
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clock)
      if (!reset) check_val("ready_onehot", 128'($countones(req_ready) <= 1), 128'd1);

   task automatic set_req(input int i, input logic [2:0] sel, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      req_sel[3*i +: 3]  = sel;
      req_op[3*i +: 3]   = op;
      req_in1[32*i +: 32] = a;
      req_in2[32*i +: 32] = b;
      req_valid[i]        = 1'b1;
   endtask

   task automatic rand_req(input int i, input bit allow_rej);
      logic [2:0] sel;
      sel = (allow_rej && ($urandom % 4 == 0)) ? 3'($urandom_range(1, 7)) : ARITH;
      set_req(i, sel, 3'($urandom), $urandom, $urandom);
   endtask

   // Entered and left at a falling edge with the DUT idle and at least one request valid.
   task automatic do_txn(input int ack_delay, input bit refill);
      int          w;
      logic [31:0] a, b, exp_data;
      logic [2:0]  sel, op;
      bit          rej;
      w = -1;
      for (int off = 4; off >= 1; off--)
         if (req_valid[(m_ptr + off) % 4]) w = (m_ptr + off) % 4;
      if (w < 0) begin
         $display("FAIL do_txn: no valid requester to serve");
         $fatal(1, "bench sequencing error");
      end
      #1;
      check_val("ready", req_ready, 4'b1 << w);
      sel = req_sel[3*w +: 3];
      op  = req_op[3*w +: 3];
      a   = req_in1[32*w +: 32];
      b   = req_in2[32*w +: 32];
      rej = (sel != ARITH);
      exp_data = rej ? 32'd0 : alu_f(op, a, b);
      m_ptr = w;
      @(posedge clock);
      @(negedge clock);
      if (refill) rand_req(w, 1'b0);
      else req_valid[w] = 1'b0;
      if (!rej) begin
         check_val("issue_en", alu_enable, 1'b1);
         check_val("issue_in1", alu_in1, a);
         check_val("issue_in2", alu_in2, b);
         check_val("issue_op", alu_operation, op);
         check_val("issue_sel", alu_opselect, ARITH);
         check_val("issue_rv", resp_valid, 4'b0);
         check_val("issue_ready", req_ready, 4'b0);
         @(negedge clock);
         check_val("capture_en", alu_enable, 1'b0);
         check_val("capture_rv", resp_valid, 4'b0);
         @(negedge clock);
         m_count++;
      end else begin
         check_val("reject_en", alu_enable, 1'b0);
      end
      check_val("resp_valid", resp_valid, 4'b1 << w);
      check_val("resp_data", resp_data, exp_data);
      check_val("resp_err", resp_err, rej);
      check_val("op_count", op_count, m_count);
      for (int d = 0; d < ack_delay; d++) begin
         resp_ack = 4'($urandom) & ~(4'b1 << w);
         @(negedge clock);
         check_val("hold_ready", req_ready, 4'b0);
         check_val("hold_rv", resp_valid, 4'b1 << w);
         check_val("hold_data", resp_data, exp_data);
      end
      resp_ack = 4'($urandom) | (4'b1 << w);
      @(negedge clock);
      resp_ack = '0;
      check_val("ack_rv", resp_valid, 4'b0);
      $display("[TB] txn req=%0d sel=%0d op=%0d in1=%08h in2=%08h exp_data=%08h err=%0d ack_delay=%0d",
               w, sel, op, a, b, exp_data, rej, ack_delay);
   endtask

   task automatic do_reset();
      req_valid = '0;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_ptr = 3;
      m_count = '0;
      @(negedge clock);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check_val("rst_rv", resp_valid, 4'b0);
      check_val("rst_en", alu_enable, 1'b0);
      check_val("rst_opsel", alu_opselect, ARITH);
      check_val("rst_count", op_count, 16'd0);
      check_val("rst_data", resp_data, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      set_req(0, ARITH, OP_ADD, 32'd5, 32'd7);
      do_txn(0, 1'b0);
      set_req(2, ARITH, OP_SUB, 32'd3, 32'd10);
      do_txn(1, 1'b0);
      set_req(2, ARITH, OP_HADD, 32'h0001FFFF, 32'h00030001);
      do_txn(0, 1'b0);
      set_req(1, 3'b101, OP_ADD, 32'd1, 32'd2);
      do_txn(2, 1'b0);

      // Continuous contention from all four requesters after a fresh reset: 0,1,2,3,0,1.
      do_reset();
      for (int i = 0; i < 4; i++) rand_req(i, 1'b0);
      for (int n = 0; n < 6; n++) do_txn(0, 1'b1);
      req_valid = '0;

      // Long ack stall with contenders waiting.
      for (int i = 0; i < 4; i++) rand_req(i, 1'b1);
      do_txn(10, 1'b0);
      while (req_valid != 0) do_txn($urandom_range(0, 2), 1'b0);

      // Reset in the CAPTURE cycle drops the operation.
      set_req(0, ARITH, OP_ADD, 32'd9, 32'd9);
      #1;
      check_val("pre_rst_ready", req_ready != 0, 1'b1);
      @(posedge clock);
      @(negedge clock);
      req_valid = '0;
      check_val("pre_rst_en", alu_enable, 1'b1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_val("midrst_rv", resp_valid, 4'b0);
      check_val("midrst_en", alu_enable, 1'b0);
      check_val("midrst_in1", alu_in1, 32'd0);
      check_val("midrst_in2", alu_in2, 32'd0);
      check_val("midrst_op", alu_operation, 3'd0);
      check_val("midrst_opsel", alu_opselect, ARITH);
      check_val("midrst_data", resp_data, 32'd0);
      check_val("midrst_err", resp_err, 1'b0);
      check_val("midrst_count", op_count, 16'd0);
      @(negedge clock);
      check_val("midrst_rv2", resp_valid, 4'b0);
      reset = 1'b0;
      m_ptr = 3;
      m_count = '0;
      @(negedge clock);
      check_val("post_rst_rv", resp_valid, 4'b0);
      set_req(0, ARITH, OP_ADD, 32'd5, 32'd7);
      do_txn(0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req_valid[i] && ($urandom % 2 == 0)) rand_req(i, 1'b1);
            else if (req_valid[i] && ($urandom % 8 == 0)) req_valid[i] = 1'b0;
         end
         if (req_valid == 0) rand_req($urandom % 4, 1'b1);
         do_txn($urandom_range(0, 3), 1'b0);
      end
      req_valid = '0;
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
